// File: rtl/tdot_sched_pkg.sv
// Shared types and defaults for the time-shared dot-product sequencer.
package tdot_pkg;

    localparam int TDOT_WIDTH   = 8;
    localparam int TDOT_TERMS   = 3;
    localparam int TDOT_MAC_LAT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Index width for a counter over n values; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdot_sched_if.sv
// Operand/result handshakes plus the operand and result wires of the external MAC.
interface tdot_sched_if #(
    parameter int WIDTH = 8,
    parameter int TERMS = 3
);
    logic                   in_valid;
    logic                   in_ready;
    logic [TERMS*WIDTH-1:0] in_a;
    logic [TERMS*WIDTH-1:0] in_b;
    logic [WIDTH-1:0]       in_c;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_y;
    logic                   busy;
    logic [WIDTH-1:0]       mac_a;
    logic [WIDTH-1:0]       mac_b;
    logic [WIDTH-1:0]       mac_c;
    logic                   mac_en;
    logic [WIDTH-1:0]       mac_p;

    modport slave (
        input  in_valid, in_a, in_b, in_c, out_ready, mac_p,
        output in_ready, out_valid, out_y, busy, mac_a, mac_b, mac_c, mac_en
    );

    modport master (
        output in_valid, in_a, in_b, in_c, out_ready, mac_p,
        input  in_ready, out_valid, out_y, busy, mac_a, mac_b, mac_c, mac_en
    );
endinterface

// File: rtl/tdot_sched.sv
// Sequences TERMS products through one pipelined MAC: y = c + sum(a[k]*b[k]) mod 2^WIDTH.
//
// state | meaning
// IDLE  | waiting for an operand vector, in_ready high
// RUN   | feeding term k to the MAC, cnt counts MAC_LAT+1 cycles per term
// DONE  | result on out_y, held until out_ready
module tdot_sched
    import tdot_pkg::*;
#(
    parameter int WIDTH   = TDOT_WIDTH,
    parameter int TERMS   = TDOT_TERMS,
    parameter int MAC_LAT = TDOT_MAC_LAT
) (
    input logic         clk,
    input logic         reset,
    tdot_sched_if.slave bus
);

    localparam int KW = idx_w(TERMS);
    localparam int CW = idx_w(MAC_LAT + 1);

    state_e                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d, k_inc;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic [TERMS*WIDTH-1:0] a_q, a_d;
    logic [TERMS*WIDTH-1:0] b_q, b_d;
    logic [TERMS*WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-1:0]       out_y_q, out_y_d;
    logic [WIDTH-1:0]       mac_a_q, mac_a_d;
    logic [WIDTH-1:0]       mac_b_q, mac_b_d;

    assign k_inc = k_q + KW'(1);
    assign a_sh  = a_q >> (k_inc * WIDTH);
    assign b_sh  = b_q >> (k_inc * WIDTH);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        out_y_d = out_y_q;
        mac_a_d = mac_a_q;
        mac_b_d = mac_b_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    acc_d   = bus.in_c;
                    k_d     = '0;
                    cnt_d   = '0;
                    mac_a_d = bus.in_a[WIDTH-1:0];
                    mac_b_d = bus.in_b[WIDTH-1:0];
                    state_d = RUN;
                end
            end
            RUN: begin
                // mac_p is only trusted once the operands have flushed all MAC_LAT stages
                if (cnt_q == CW'(MAC_LAT)) begin
                    cnt_d = '0;
                    acc_d = bus.mac_p;
                    if (k_q == KW'(TERMS - 1)) begin
                        out_y_d = bus.mac_p;
                        state_d = DONE;
                    end else begin
                        k_d     = k_inc;
                        mac_a_d = a_sh[WIDTH-1:0];
                        mac_b_d = b_sh[WIDTH-1:0];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_y_q <= '0;
            mac_a_q <= '0;
            mac_b_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_y_q <= out_y_d;
            mac_a_q <= mac_a_d;
            mac_b_q <= mac_b_d;
        end
    end

    // Status decodes straight off the state flop so an async reset clears them at once.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.mac_en    = (state_q == RUN);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_y     = out_y_q;
    assign bus.mac_a     = mac_a_q;
    assign bus.mac_b     = mac_b_q;
    assign bus.mac_c     = acc_q;

endmodule

// File: tb/tb_tdot_sched.sv
// Directed bench for tdot_sched with a behavioural MAC pipeline on the mac_* wires.
module tb_tdot_sched;
    import tdot_pkg::*;

    localparam int WIDTH    = 8;
    localparam int TERMS    = 3;
    localparam int MAC_LAT  = 3;
    localparam int TERM_CYC = MAC_LAT + 1;
    localparam int LAT      = TERMS * TERM_CYC + 1;
    localparam int PERIOD   = TERMS * TERM_CYC + 2;

    typedef struct {
        logic [TERMS*WIDTH-1:0] a;
        logic [TERMS*WIDTH-1:0] b;
        logic [WIDTH-1:0]       c;
        logic [WIDTH-1:0]       y;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   hs_cnt = 0;

    always #5 clk = ~clk;

    tdot_sched_if #(.WIDTH(WIDTH), .TERMS(TERMS)) bus ();

    tdot_sched #(.WIDTH(WIDTH), .TERMS(TERMS), .MAC_LAT(MAC_LAT)) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    // mac_model: MAC_LAT-stage enabled pipeline computing (A*B+C) mod 2^WIDTH
    logic [WIDTH-1:0] pipe [MAC_LAT];
    always @(posedge clk) begin
        if (bus.mac_en) begin
            pipe[0] <= bus.mac_a * bus.mac_b + bus.mac_c;
            for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign bus.mac_p = pipe[MAC_LAT-1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;
    end

    function automatic logic [TERMS*WIDTH-1:0] pk(input int x0, input int x1, input int x2);
        return {x2[WIDTH-1:0], x1[WIDTH-1:0], x0[WIDTH-1:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_a     = v.a;
        bus.in_b     = v.b;
        bus.in_c     = v.c;
        bus.in_valid = 1'b1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_in_ready"}, bus.in_ready, 1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Entered and left at a negedge with the DUT idle and out_ready high.
    task automatic run_vec(input string name, input vec_t v);
        int lat;
        drive(v);
        wait_ready(name);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        chk({name, "_latency"}, lat, LAT);
        chk({name, "_y"}, bus.out_y, v.y);
        @(negedge clk);
        chk({name, "_valid_1cyc"}, bus.out_valid, 0);
    endtask

    vec_t vecs[7];
    vec_t b2b[4];
    logic [WIDTH-1:0] ea[TERMS];
    logic [WIDTH-1:0] eb[TERMS];
    logic [WIDTH-1:0] ec[TERMS];

    initial begin
        int lat;
        int hs0;
        int acc_cyc;
        int prev_cyc;
        int term;
        vec_t v;

        vecs[0] = '{pk(1, 2, 3),       pk(4, 5, 6),       8'd7,   8'd39};
        vecs[1] = '{pk(255, 255, 255), pk(255, 255, 255), 8'd0,   8'd3};
        vecs[2] = '{pk(255, 255, 255), pk(255, 255, 255), 8'd254, 8'd1};
        vecs[3] = '{pk(0, 0, 0),       pk(9, 9, 9),       8'h55,  8'h55};
        vecs[4] = '{pk(16, 16, 16),    pk(16, 16, 16),    8'd1,   8'd1};
        vecs[5] = '{pk(10, 20, 30),    pk(3, 2, 1),       8'd100, 8'd200};
        vecs[6] = '{pk(200, 1, 0),     pk(2, 1, 0),       8'd50,  8'd195};

        b2b[0] = '{pk(1, 2, 3),     pk(4, 5, 6), 8'd7,   8'd39};
        b2b[1] = '{pk(3, 3, 3),     pk(3, 3, 3), 8'd0,   8'd27};
        b2b[2] = '{pk(100, 50, 25), pk(2, 4, 8), 8'd6,   8'd94};
        b2b[3] = '{pk(9, 8, 7),     pk(1, 1, 1), 8'd200, 8'd224};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_c      = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_in_ready",  bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy",      bus.busy, 0);
        chk("rst_mac_en",    bus.mac_en, 0);
        chk("rst_out_y",     bus.out_y, 0);
        chk("rst_mac_a",     bus.mac_a, 0);
        chk("rst_mac_b",     bus.mac_b, 0);
        chk("rst_mac_c",     bus.mac_c, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // backpressure
        v = '{pk(1, 1, 1), pk(1, 1, 1), 8'd0, 8'd3};
        bus.out_ready = 1'b0;
        drive(v);
        wait_ready("bp");
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_latency", lat, LAT);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_y",     bus.out_y, 3);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready",  bus.in_ready, 0);
            chk("bp_mac_en",    bus.mac_en, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready",  bus.in_ready, 1);
        chk("bp_release_out_valid", bus.out_valid, 0);

        // reset in RUN at k=1, cnt=2 (cycle 7 after accept)
        v = '{pk(5, 6, 7), pk(1, 2, 3), 8'd4, 8'd42};
        drive(v);
        wait_ready("rstmid");
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("rstmid_busy_before", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", bus.out_valid, 0);
        chk("rstmid_mac_en",    bus.mac_en, 0);
        chk("rstmid_busy",      bus.busy, 0);
        chk("rstmid_in_ready",  bus.in_ready, 1);
        chk("rstmid_out_y",     bus.out_y, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec("after_rst", '{pk(2, 2, 2), pk(3, 3, 3), 8'd1, 8'd19});

        // operand stability: inputs scrambled every cycle after acceptance
        ea = '{8'd7, 8'd11, 8'd13};
        eb = '{8'd5, 8'd3, 8'd2};
        ec = '{8'd9, 8'd44, 8'd77};
        drive('{pk(7, 11, 13), pk(5, 3, 2), 8'd9, 8'd103});
        wait_ready("stab");
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int c = 1; c <= TERMS * TERM_CYC; c++) begin
            term = (c - 1) / TERM_CYC;
            chk($sformatf("stab_mac_a_c%0d", c), bus.mac_a, ea[term]);
            chk($sformatf("stab_mac_b_c%0d", c), bus.mac_b, eb[term]);
            chk($sformatf("stab_mac_c_c%0d", c), bus.mac_c, ec[term]);
            bus.in_a = {$urandom, $urandom};
            bus.in_b = {$urandom, $urandom};
            bus.in_c = 8'($urandom);
            @(negedge clk);
        end
        chk("stab_out_valid", bus.out_valid, 1);
        chk("stab_y",         bus.out_y, 103);
        @(negedge clk);

        // back-to-back with in_valid held high
        hs0 = hs_cnt;
        prev_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(b2b[i]);
            wait_ready($sformatf("b2b%0d", i));
            acc_cyc = cyc;
            if (i > 0) chk($sformatf("b2b%0d_spacing", i), acc_cyc - prev_cyc, PERIOD);
            prev_cyc = acc_cyc;
            @(negedge clk);
            wait_valid(lat);
            chk($sformatf("b2b%0d_latency", i), lat, LAT);
            chk($sformatf("b2b%0d_y", i), bus.out_y, b2b[i].y);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_handshakes", hs_cnt - hs0, 4);
        chk("b2b_idle_valid", bus.out_valid, 0);
        repeat (3) @(negedge clk);
        chk("b2b_no_extra", hs_cnt - hs0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
